// File: rtl/ethernet_pkg.sv
// Shared Ethernet datapath types and AXI-Stream keep helpers.
package ethernet_pkg;

  localparam int unsigned AXIS_DATA_W = 64;
  localparam int unsigned AXIS_KEEP_W = 8;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tlast;
    logic                   tuser;
  } axis64_beat_t;

  // Number of valid bytes in a beat.
  function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + 4'(keep[i]);
    return n;
  endfunction

  // True when keep is of the form 2^k-1 (valid bytes packed from lane 0).
  function automatic bit keep_is_contig(input logic [7:0] keep);
    logic [7:0] inc;
    inc = keep + 8'd1;
    return (keep & inc) == 8'd0;
  endfunction

endpackage

// File: rtl/eth_tx_pacer_if.sv
// Generator-side and MAC-side AXI-Stream signals of the TX pacer.
interface eth_tx_pacer_if;
  import ethernet_pkg::*;

  logic                   s_axis_tready;
  logic                   s_axis_tvalid;
  logic [AXIS_DATA_W-1:0] s_axis_tdata;
  logic [AXIS_KEEP_W-1:0] s_axis_tkeep;
  logic                   s_axis_tlast;
  logic                   s_axis_tuser;

  logic                   m_axis_tready;
  logic                   m_axis_tvalid;
  logic [AXIS_DATA_W-1:0] m_axis_tdata;
  logic [AXIS_KEEP_W-1:0] m_axis_tkeep;
  logic                   m_axis_tlast;
  logic                   m_axis_tuser;

  // The pacer itself: drives tready upstream and the master stream downstream.
  modport master (
    output s_axis_tready,
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
    input  m_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser
  );

  // Surrounding generator + MAC.
  modport slave (
    input  s_axis_tready,
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
    output m_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser
  );

endinterface

// File: rtl/axis_skid64.sv
// Two-entry register slice (main + skid) for axis64 beats; full rate, outputs from flops.
module axis_skid64
  import ethernet_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  axis64_beat_t in_beat,
  output logic         out_valid,
  output axis64_beat_t out_beat,
  input  logic         out_ready
);

  logic         skid_valid;
  axis64_beat_t skid_beat;
  logic         in_fire;

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && !skid_valid;

  // Main register refills from skid first to keep ordering; skid only catches a stalled beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_beat   <= skid_beat;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_beat <= in_beat;
      end
    end else if (in_fire) begin
      skid_beat  <= in_beat;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/eth_tx_pacer.sv
// TX pacer: forwards 64-bit frames to the MAC, enforces a cycle-count inter-frame gap, keeps stats.
module eth_tx_pacer
  import ethernet_pkg::*;
#(
  parameter logic [27:0] IFG_DEFAULT = 28'h00FFFF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk156,
  input  logic                sys_rst_n,
  input  logic                enable,
  input  logic                ifg_sel,
  input  logic [27:0]         ifg_len,
  input  logic                stats_clr,
  eth_tx_pacer_if.master      axis,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W+15:0]   byte_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic                busy
);

  localparam int unsigned IFG_W  = 28;
  localparam int unsigned BYTE_W = CNT_W + 16;

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_GAP} state_t;

  state_t             state_q, state_d;
  logic               enable_q;
  logic [IFG_W-1:0]   gap_cnt_q;
  logic [IFG_W-1:0]   gap_len;
  logic               allow;
  logic               skid_in_ready;
  logic               s_fire;
  axis64_beat_t       s_beat, m_beat;
  logic               m_valid, m_fire;
  logic               bad_beat, err_sticky_q;

  assign s_beat = '{tdata: axis.s_axis_tdata, tkeep: axis.s_axis_tkeep,
                    tlast: axis.s_axis_tlast, tuser: axis.s_axis_tuser};
  assign axis.s_axis_tready = allow && skid_in_ready;
  assign s_fire  = axis.s_axis_tvalid && axis.s_axis_tready;
  assign gap_len = ifg_sel ? ifg_len : IFG_DEFAULT;

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable;
    end
  end

  // A zero-length gap skips GAP entirely so frames can run back-to-back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (s_fire) state_d = s_beat.tlast ? ((gap_len == '0) ? ST_IDLE : ST_GAP) : ST_PASS;
      ST_PASS: if (s_fire && s_beat.tlast) state_d = (gap_len == '0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (gap_cnt_q <= IFG_W'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    allow = 1'b0;
    busy  = 1'b0;
    allow = (state_q == ST_PASS) || (state_q == ST_IDLE && enable_q);
    busy  = (state_q != ST_IDLE) || m_valid;
  end

  // Loaded on the tlast acceptance; counts real time regardless of downstream stalls.
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n)                      gap_cnt_q <= '0;
    else if (s_fire && s_beat.tlast)     gap_cnt_q <= gap_len;
    else if (state_q == ST_GAP && gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - IFG_W'(1);
  end

  axis_skid64 u_skid (
    .clk       (clk156),
    .rst_n     (sys_rst_n),
    .in_valid  (axis.s_axis_tvalid && allow),
    .in_ready  (skid_in_ready),
    .in_beat   (s_beat),
    .out_valid (m_valid),
    .out_beat  (m_beat),
    .out_ready (axis.m_axis_tready)
  );

  assign axis.m_axis_tvalid = m_valid;
  assign axis.m_axis_tdata  = m_beat.tdata;
  assign axis.m_axis_tkeep  = m_beat.tkeep;
  assign axis.m_axis_tlast  = m_beat.tlast;
  assign axis.m_axis_tuser  = m_beat.tuser;

  assign m_fire   = m_valid && axis.m_axis_tready;
  assign bad_beat = m_beat.tuser || !keep_is_contig(m_beat.tkeep) ||
                    (!m_beat.tlast && m_beat.tkeep != 8'hFF);

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n)  err_sticky_q <= 1'b0;
    else if (m_fire) err_sticky_q <= m_beat.tlast ? 1'b0 : (err_sticky_q || bad_beat);
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt <= '0;
      byte_cnt  <= '0;
      err_cnt   <= '0;
    end else if (stats_clr) begin
      frame_cnt <= '0;
      byte_cnt  <= '0;
      err_cnt   <= '0;
    end else if (m_fire) begin
      byte_cnt <= byte_cnt + BYTE_W'(keep_popcount(m_beat.tkeep));
      if (m_beat.tlast) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        if (err_sticky_q || bad_beat) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_pacer.sv
// Directed bench for eth_tx_pacer with an output scoreboard and stall-stability monitor.
module tb_eth_tx_pacer;
  import ethernet_pkg::*;

  localparam int unsigned CNT_W = 8;

  logic              clk156 = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              ifg_sel = 1'b1;
  logic [27:0]       ifg_len = 28'd0;
  logic              stats_clr = 1'b0;
  logic [CNT_W-1:0]  frame_cnt, err_cnt;
  logic [CNT_W+15:0] byte_cnt;
  logic              busy;

  eth_tx_pacer_if axis ();

  eth_tx_pacer #(.IFG_DEFAULT(28'd7), .CNT_W(CNT_W)) dut (
    .clk156    (clk156),
    .sys_rst_n (sys_rst_n),
    .enable    (enable),
    .ifg_sel   (ifg_sel),
    .ifg_len   (ifg_len),
    .stats_clr (stats_clr),
    .axis      (axis),
    .frame_cnt (frame_cnt),
    .byte_cnt  (byte_cnt),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  always #3 clk156 = ~clk156;

  int checks = 0;
  int errors = 0;
  int sb_err = 0;
  int cyc = 0;
  int hs_cnt = 0, mark = 0, first_cyc = 0, last_cyc = 0;
  int bp_mode = 0;
  axis64_beat_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input int seed, input int i);
    return {16'(seed), 16'(i) ^ 16'hBEEF, 32'(i) * 32'h9E3779B1};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk156);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    axis64_beat_t b;
    logic ok;
    b = '{tdata: d, tkeep: k, tlast: l, tuser: u};
    axis.s_axis_tvalid = 1'b1;
    axis.s_axis_tdata  = d;
    axis.s_axis_tkeep  = k;
    axis.s_axis_tlast  = l;
    axis.s_axis_tuser  = u;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk156);
      if (axis.s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) exp_q.push_back(b);
    else check("send_timeout", 64'(ok), 64'd1);
    @(posedge clk156);
    #1;
    axis.s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int seed, input int n, input logic [7:0] last_keep,
                            input int user_at, input int drop_at);
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) enable = 1'b0;
      send_beat(beat_data(seed, i), (i == n - 1) ? last_keep : 8'hFF, i == n - 1, i == user_at);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk156);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    tick(2);
  endtask

  task automatic measure_gap(output int lo);
    lo = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk156);
      if (axis.s_axis_tready) break;
      lo++;
    end
  endtask

  task automatic pulse_clr();
    stats_clr = 1'b1;
    tick(1);
    stats_clr = 1'b0;
  endtask

  // Downstream ready: 0 = always ready, 1 = random 50%, 2 = stalled.
  initial begin
    axis.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk156);
      #1;
      case (bp_mode)
        0:       axis.m_axis_tready = 1'b1;
        1:       axis.m_axis_tready = 1'($urandom_range(0, 1));
        default: axis.m_axis_tready = 1'b0;
      endcase
    end
  end

  initial forever begin
    @(posedge clk156);
    cyc++;
  end

  // Scoreboard + "no valid drop / no data change while stalled" monitor.
  initial begin
    axis64_beat_t cur, prev;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk156);
      cur = '{tdata: axis.m_axis_tdata, tkeep: axis.m_axis_tkeep,
              tlast: axis.m_axis_tlast, tuser: axis.m_axis_tuser};
      if (!sys_rst_n) begin
        prev_stall = 1'b0;
        exp_q.delete();
      end else begin
        if (prev_stall && (!axis.m_axis_tvalid || cur !== prev)) sb_err++;
        if (axis.m_axis_tvalid && axis.m_axis_tready) begin
          if (exp_q.size() == 0) sb_err++;
          else begin
            if (exp_q[0] !== cur) sb_err++;
            void'(exp_q.pop_front());
          end
          if (hs_cnt == mark) first_cyc = cyc;
          last_cyc = cyc;
          hs_cnt++;
        end
        prev_stall = axis.m_axis_tvalid && !axis.m_axis_tready;
        prev = cur;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, hi;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tdata  = '0;
    axis.s_axis_tkeep  = '0;
    axis.s_axis_tlast  = 1'b0;
    axis.s_axis_tuser  = 1'b0;

    tick(3);
    check("rst_m_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
    check("rst_m_tdata", axis.m_axis_tdata, 64'd0);
    check("rst_s_tready", 64'(axis.s_axis_tready), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_byte_cnt", 64'(byte_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    sys_rst_n = 1'b1;
    tick(3);
    check("tready_no_enable", 64'(axis.s_axis_tready), 64'd0);
    enable  = 1'b1;
    ifg_sel = 1'b1;
    ifg_len = 28'd10;
    tick(2);
    check("tready_enabled", 64'(axis.s_axis_tready), 64'd1);

    // Nominal 128-beat frame, 1-cycle latency, 10-cycle gap.
    check("pre_m_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
    send_beat(beat_data(1, 0), 8'hFF, 1'b0, 1'b0);
    check("lat_m_tvalid", 64'(axis.m_axis_tvalid), 64'd1);
    check("lat_m_tdata", axis.m_axis_tdata, beat_data(1, 0));
    for (int i = 1; i < 128; i++)
      send_beat(beat_data(1, i), (i == 127) ? 8'h0F : 8'hFF, i == 127, 1'b0);
    measure_gap(lo);
    check("gap_len10", 64'(lo), 64'd10);
    drain();
    check("nom_frame_cnt", 64'(frame_cnt), 64'd1);
    check("nom_byte_cnt", 64'(byte_cnt), 64'd1020);
    check("nom_sb", 64'(sb_err), 64'd0);

    // Default gap (IFG_DEFAULT=7 on this instance).
    ifg_sel = 1'b0;
    send_frame(9, 2, 8'hFF, -1, -1);
    measure_gap(lo);
    check("gap_default", 64'(lo), 64'd7);
    ifg_sel = 1'b1;
    drain();

    // Back-to-back with zero gap.
    pulse_clr();
    ifg_len = 28'd0;
    mark = hs_cnt;
    for (int f = 0; f < 3; f++) send_frame(2 + f, 128, 8'h0F, -1, -1);
    drain();
    check("b2b_beats", 64'(hs_cnt - mark), 64'd384);
    check("b2b_span", 64'(last_cyc - first_cyc), 64'd383);
    check("b2b_frame_cnt", 64'(frame_cnt), 64'd3);
    check("b2b_byte_cnt", 64'(byte_cnt), 64'd3060);

    // Random downstream back-pressure.
    pulse_clr();
    ifg_len = 28'd4;
    bp_mode = 1;
    send_frame(5, 128, 8'h0F, -1, -1);
    send_frame(6, 128, 8'h0F, -1, -1);
    drain();
    bp_mode = 0;
    tick(2);
    check("bp_frame_cnt", 64'(frame_cnt), 64'd2);
    check("bp_byte_cnt", 64'(byte_cnt), 64'd2040);
    check("bp_sb", 64'(sb_err), 64'd0);

    // Enable dropped mid-frame, then error frames.
    pulse_clr();
    ifg_len = 28'd3;
    send_frame(7, 128, 8'h0F, -1, 40);
    tick(10);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk156);
      if (axis.s_axis_tready) hi++;
    end
    check("parked_no_start", 64'(hi), 64'd0);
    drain();
    check("parked_busy", 64'(busy), 64'd0);
    check("parked_frame_cnt", 64'(frame_cnt), 64'd1);
    enable = 1'b1;
    send_frame(8, 16, 8'hFF, 5, -1);
    send_frame(10, 8, 8'h05, -1, -1);
    drain();
    check("err_err_cnt", 64'(err_cnt), 64'd2);
    check("err_frame_cnt", 64'(frame_cnt), 64'd3);
    check("err_byte_cnt", 64'(byte_cnt), 64'd1206);
    check("err_sb", 64'(sb_err), 64'd0);

    // 260 single-beat bad frames: 8-bit counters wrap to 4.
    pulse_clr();
    ifg_len = 28'd0;
    for (int i = 0; i < 260; i++) send_beat(beat_data(11, i), 8'hFF, 1'b1, 1'b1);
    drain();
    check("wrap_frame_cnt", 64'(frame_cnt), 64'd4);
    check("wrap_err_cnt", 64'(err_cnt), 64'd4);
    check("wrap_byte_cnt", 64'(byte_cnt), 64'd2080);

    // Clear coincident with the tlast handshake wins.
    send_frame(30, 4, 8'hFF, -1, -1);
    pulse_clr();
    check("clr_frame_cnt", 64'(frame_cnt), 64'd0);
    check("clr_byte_cnt", 64'(byte_cnt), 64'd0);
    send_frame(31, 1, 8'hFF, -1, -1);
    drain();
    check("post_clr_frame_cnt", 64'(frame_cnt), 64'd1);
    check("post_clr_byte_cnt", 64'(byte_cnt), 64'd8);
    check("final_sb", 64'(sb_err), 64'd0);

    // Stall fills both entries, then reset asserts mid-frame.
    bp_mode = 2;
    tick(2);
    send_frame(20, 2, 8'hFF, -1, 5);
    enable = 1'b1;
    tick(1);
    check("full_m_tvalid", 64'(axis.m_axis_tvalid), 64'd1);
    check("full_s_tready", 64'(axis.s_axis_tready), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    sys_rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("async_m_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
    check("async_frame_cnt", 64'(frame_cnt), 64'd0);
    check("async_byte_cnt", 64'(byte_cnt), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    tick(2);
    sys_rst_n = 1'b1;
    bp_mode = 0;
    tick(3);
    check("post_rst_tready", 64'(axis.s_axis_tready), 64'd0);
    enable = 1'b1;
    tick(2);
    check("post_rst_tready_en", 64'(axis.s_axis_tready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
